// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver.
// Holds the ASCII byte constants the parser reacts to, the magnitude saturation
// limit, the FSM state types for the RX front end and the line parser, and small
// helpers for digit classification and saturating decimal accumulation.
package uart_cmd_pkg;

    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;

    // Magnitude ceiling: large enough to represent -32768 exactly.
    localparam logic [16:0] MAG_SAT = 17'd32768;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        PsSep,
        PsSign,
        PsDigit,
        PsDiscard
    } ps_state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ZERO) && (b <= NINE);
    endfunction

    // mag*10 + digit built from shifts, clamped to MAG_SAT. Inputs never exceed
    // MAG_SAT, so 20 bits cannot overflow.
    function automatic logic [16:0] mag_step(input logic [16:0] mag, input logic [3:0] digit);
        logic [19:0] wide;
        wide = ({3'b000, mag} << 3) + ({3'b000, mag} << 1) + {16'd0, digit};
        if (wide > {3'b000, MAG_SAT}) begin
            return MAG_SAT;
        end
        return wide[16:0];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver front end: 8 data bits, no parity, 1 stop bit.
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   rx_i          asynchronous serial line, idle high
//   byte_valid_o  one-cycle strobe, byte_o holds a correctly framed byte
//   byte_o        received data byte
//   frame_err_o   one-cycle strobe, stop bit sampled low (byte discarded)
module uart_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 217
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLK_DIV - 1);

    rx_state_e state_q, state_d;

    logic            rx_meta_q, rx_sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    logic half_tick;
    logic bit_tick;

    assign half_tick = (cnt_q == HalfLast);
    assign bit_tick  = (cnt_q == BitLast);

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    state_d = RxStart;
                end
            end
            RxStart: begin
                // Mid-start-bit resample filters out short glitches.
                if (half_tick) begin
                    state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (bit_tick && (bit_idx_q == 3'd7)) begin
                    state_d = RxStop;
                end
            end
            RxStop: begin
                if (bit_tick) begin
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    // Bit timing and shift register
    always_comb begin
        cnt_d     = cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
            end
            RxStart: begin
                if (half_tick) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end
            end
            RxData: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                end
            end
            RxStop: begin
                if (bit_tick) begin
                    cnt_d = '0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Outputs
    always_comb begin
        byte_valid_o = (state_q == RxStop) && bit_tick && rx_sync_q;
        frame_err_o  = (state_q == RxStop) && bit_tick && !rx_sync_q;
        byte_o       = shift_q;
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command line receiver. Parses text lines of up to four signed decimal
// integers separated by spaces (CR tolerated) and terminated by LF, and commits
// all fields of a line atomically.
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   i_uart_rx       asynchronous serial input, idle high
//   o_en            one-cycle strobe: a line was committed
//   o_mask          bit k = field k present in the committed line (valid with o_en)
//   o_val0..o_val3  signed 16-bit field values, held until overwritten
//   o_err           one-cycle strobe: line rejected or stop-bit framing error
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 217
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_uart_rx,
    output logic               o_en,
    output logic [3:0]         o_mask,
    output logic signed [15:0] o_val0,
    output logic signed [15:0] o_val1,
    output logic signed [15:0] o_val2,
    output logic signed [15:0] o_val3,
    output logic               o_err
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_rx (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (i_uart_rx),
        .byte_valid_o (byte_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (frame_err)
    );

    ps_state_e ps_q, ps_d;

    logic        neg_q, neg_d;
    logic [16:0] mag_q, mag_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q [4];
    logic [15:0] shadow_d [4];
    logic        en_q, en_d;
    logic [3:0]  omask_q, omask_d;
    logic [15:0] val_q [4];
    logic [15:0] val_d [4];
    logic        err_q, err_d;

    // Byte classification
    logic       is_dig, is_ws, is_lf, is_minus;
    logic [3:0] digit;

    assign is_dig   = is_digit(rx_byte);
    assign is_ws    = (rx_byte == SP) || (rx_byte == CR);
    assign is_lf    = (rx_byte == LF);
    assign is_minus = (rx_byte == MINUS);
    assign digit    = rx_byte[3:0];

    // Parser events for the current byte strobe
    logic ev_start_neg, ev_first_digit, ev_accum, ev_commit, ev_eol, ev_drop, err_raw;
    logic overflow, parse_err;

    always_comb begin
        ev_start_neg   = 1'b0;
        ev_first_digit = 1'b0;
        ev_accum       = 1'b0;
        ev_commit      = 1'b0;
        ev_eol         = 1'b0;
        ev_drop        = 1'b0;
        err_raw        = 1'b0;
        if (byte_valid) begin
            unique case (ps_q)
                PsSep: begin
                    if (is_dig) begin
                        ev_first_digit = 1'b1;
                    end else if (is_minus) begin
                        ev_start_neg = 1'b1;
                    end else if (is_lf) begin
                        ev_eol = 1'b1;
                    end else if (!is_ws) begin
                        err_raw = 1'b1;
                    end
                end
                PsSign: begin
                    if (is_dig) begin
                        ev_first_digit = 1'b1;
                    end else begin
                        err_raw = 1'b1;
                    end
                end
                PsDigit: begin
                    if (is_dig) begin
                        ev_accum = 1'b1;
                    end else if (is_ws) begin
                        ev_commit = 1'b1;
                    end else if (is_lf) begin
                        ev_commit = 1'b1;
                        ev_eol    = 1'b1;
                    end else begin
                        err_raw = 1'b1;
                    end
                end
                PsDiscard: begin
                    ev_drop = is_lf;
                end
                default: err_raw = 1'b1;
            endcase
        end
    end

    // A fifth field has nowhere to go.
    assign overflow  = ev_commit && (fcnt_q == 3'd4);
    assign parse_err = err_raw || overflow;

    // Parser state register
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= PsSep;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Parser next-state logic
    always_comb begin
        ps_d = ps_q;
        if (parse_err) begin
            // An LF that is itself the offending byte already ends the line.
            ps_d = is_lf ? PsSep : PsDiscard;
        end else if (ev_eol || ev_drop || ev_commit) begin
            ps_d = PsSep;
        end else if (ev_start_neg) begin
            ps_d = PsSign;
        end else if (ev_first_digit || ev_accum) begin
            ps_d = PsDigit;
        end
    end

    // Field value as committed: negative side reaches -32768, positive clamps at 32767.
    logic [15:0] commit_val;
    logic [16:0] mag_neg;

    assign mag_neg    = 17'd0 - mag_q;
    assign commit_val = neg_q ? mag_neg[15:0]
                              : ((mag_q > 17'd32767) ? 16'h7fff : mag_q[15:0]);

    // Parser datapath and registered outputs
    always_comb begin
        neg_d    = neg_q;
        mag_d    = mag_q;
        fcnt_d   = fcnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        en_d     = 1'b0;
        omask_d  = omask_q;
        val_d    = val_q;
        err_d    = frame_err;

        if (parse_err) begin
            err_d  = 1'b1;
            neg_d  = 1'b0;
            mag_d  = 17'd0;
            fcnt_d = 3'd0;
            mask_d = 4'd0;
        end else begin
            if (ev_start_neg) begin
                neg_d = 1'b1;
            end
            if (ev_first_digit) begin
                mag_d = {13'd0, digit};
            end
            if (ev_accum) begin
                mag_d = mag_step(mag_q, digit);
            end
            if (ev_commit) begin
                shadow_d[fcnt_q[1:0]] = commit_val;
                mask_d[fcnt_q[1:0]]   = 1'b1;
                fcnt_d                = fcnt_q + 3'd1;
                neg_d                 = 1'b0;
                mag_d                 = 17'd0;
            end
            if (ev_eol) begin
                // Empty lines leave the outputs untouched and raise no strobe.
                if (mask_d != 4'd0) begin
                    en_d    = 1'b1;
                    omask_d = mask_d;
                    for (int k = 0; k < 4; k++) begin
                        if (mask_d[k]) begin
                            val_d[k] = shadow_d[k];
                        end
                    end
                end
                fcnt_d = 3'd0;
                mask_d = 4'd0;
                neg_d  = 1'b0;
                mag_d  = 17'd0;
            end
            if (ev_drop) begin
                fcnt_d = 3'd0;
                mask_d = 4'd0;
                neg_d  = 1'b0;
                mag_d  = 17'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q   <= 1'b0;
            mag_q   <= 17'd0;
            fcnt_q  <= 3'd0;
            mask_q  <= 4'd0;
            en_q    <= 1'b0;
            omask_q <= 4'd0;
            err_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                shadow_q[k] <= 16'd0;
                val_q[k]    <= 16'd0;
            end
        end else begin
            neg_q    <= neg_d;
            mag_q    <= mag_d;
            fcnt_q   <= fcnt_d;
            mask_q   <= mask_d;
            en_q     <= en_d;
            omask_q  <= omask_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            val_q    <= val_d;
        end
    end

    assign o_en   = en_q;
    assign o_mask = omask_q;
    assign o_err  = err_q;
    assign o_val0 = val_q[0];
    assign o_val1 = val_q[1];
    assign o_val2 = val_q[2];
    assign o_val3 = val_q[3];

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed lines with literal expectations plus random
// lines checked against a line-level reference model and an event scoreboard.
module tb_uart_cmd_rx;

    localparam int unsigned CLK_DIV = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               rx;
    logic               o_en;
    logic [3:0]         o_mask;
    logic signed [15:0] o_val0, o_val1, o_val2, o_val3;
    logic               o_err;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_uart_rx (rx),
        .o_en      (o_en),
        .o_mask    (o_mask),
        .o_val0    (o_val0),
        .o_val1    (o_val1),
        .o_val2    (o_val2),
        .o_val3    (o_val3),
        .o_err     (o_err)
    );

    typedef byte unsigned bq_t[$];
    typedef bit fq_t[$];
    typedef struct packed {
        logic             is_en;
        logic [3:0]       mask;
        logic [3:0][15:0] v;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  en_seen = 0;
    int  err_seen = 0;
    logic [3:0] last_mask = 4'd0;
    logic signed [15:0] mval [4];
    logic signed [15:0] dval [4];

    assign dval[0] = o_val0;
    assign dval[1] = o_val1;
    assign dval[2] = o_val2;
    assign dval[3] = o_val3;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line-level reference: 0 = empty line, 1 = valid line, 2 = rejected line.
    function automatic int eval_line(input bq_t ln, output logic [3:0] mask,
                                     output logic [3:0][15:0] v);
        int          ntok = 0;
        bit          in_tok = 0, tneg = 0, tdig = 0, bad = 0;
        longint      mag = 0;
        byte unsigned c;
        mask = 4'd0;
        v    = '0;
        for (int i = 0; i <= ln.size(); i++) begin
            c = (i == ln.size()) ? 8'h20 : ln[i];
            if (c == 8'h20 || c == 8'h0D) begin
                if (in_tok) begin
                    if (!tdig || ntok >= 4) begin
                        bad = 1;
                    end else begin
                        v[ntok] = tneg ? 16'(-((mag > 32768) ? 32768 : mag))
                                       : 16'((mag > 32767) ? 32767 : mag);
                        ntok++;
                    end
                    in_tok = 0;
                end
            end else if (c == 8'h2D) begin
                if (in_tok) bad = 1;
                else begin
                    in_tok = 1; tneg = 1; tdig = 0; mag = 0;
                end
            end else if (c >= 8'h30 && c <= 8'h39) begin
                if (!in_tok) begin
                    in_tok = 1; tneg = 0; mag = 0;
                end
                tdig = 1;
                mag  = mag * 10 + longint'(c - 8'h30);
                if (mag > 100000) mag = 100000;
            end else begin
                bad = 1;
            end
        end
        if (ntok <= 4) mask = 4'((1 << ntok) - 1);
        if (bad) return 2;
        if (ntok == 0) return 0;
        return 1;
    endfunction

    // Scoreboard: every strobe must match the next expected event; held values
    // are compared against the model every cycle outside reset.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            for (int k = 0; k < 4; k++) mval[k] = 16'sd0;
        end else begin
            check("en_err_overlap", longint'(o_en & o_err), 0);
            if (o_en || o_err) begin
                if (o_en) begin
                    en_seen++;
                    last_mask = o_mask;
                end
                if (o_err) err_seen++;
                check("event_pending", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("event_kind_en", longint'(o_en), longint'(e.is_en));
                    if (e.is_en && o_en) begin
                        check("mask", longint'(o_mask), longint'(e.mask));
                        for (int k = 0; k < 4; k++) begin
                            if (e.mask[k]) mval[k] = e.v[k];
                        end
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("val%0d", k), longint'(dval[k]), longint'(mval[k]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte unsigned b, input bit bad_stop);
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLK_DIV);
        end
        if (bad_stop) begin
            // Release early so the tail of the low stop bit is not a valid start.
            rx = 1'b0;
            tick(CLK_DIV * 3 / 4);
            rx = 1'b1;
            tick(2 * CLK_DIV);
        end else begin
            rx = 1'b1;
            tick(CLK_DIV);
        end
        tick($urandom_range(1, 3));
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic fq_t zeros(input int n);
        fq_t q;
        for (int i = 0; i < n; i++) q.push_back(1'b0);
        return q;
    endfunction

    // Sends a line (LF appended) and queues the events it must produce.
    task automatic run_line(input bq_t b, input fq_t bad);
        bq_t              ln;
        ev_t              e;
        logic [3:0]       m;
        logic [3:0][15:0] v;
        int               r;
        for (int i = 0; i < b.size(); i++) begin
            if (bad[i]) begin
                e = '0;
                exp_q.push_back(e);
            end else begin
                ln.push_back(b[i]);
            end
        end
        r = eval_line(ln, m, v);
        if (r != 0) begin
            e.is_en = (r == 1);
            e.mask  = m;
            e.v     = v;
            exp_q.push_back(e);
        end
        for (int i = 0; i < b.size(); i++) send_byte(b[i], bad[i]);
        send_byte(8'h0A, 1'b0);
        tick(4);
    endtask

    task automatic line_str(input string s);
        run_line(str2q(s), zeros(s.len()));
    endtask

    task automatic rand_line();
        bq_t          b;
        fq_t          f;
        int           r, nf, mag, pos;
        string        s;
        byte unsigned junk [5];
        junk = '{8'h61, 8'h2D, 8'h2B, 8'h2E, 8'h78};
        r  = $urandom_range(0, 9);
        nf = (r < 1) ? 0 : (r < 9) ? 1 + (r % 4) : 5;
        if ($urandom_range(0, 3) == 0) b.push_back(8'h20);
        for (int j = 0; j < nf; j++) begin
            if (j > 0) begin
                b.push_back(8'h20);
                if ($urandom_range(0, 4) == 0) b.push_back(8'h20);
            end
            case ($urandom_range(0, 2))
                0: mag = $urandom_range(0, 99);
                1: mag = $urandom_range(0, 32768);
                default: mag = $urandom_range(30000, 99999);
            endcase
            s = $sformatf("%s%0d", ($urandom_range(0, 1) == 1) ? "-" : "", mag);
            for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
        end
        if ($urandom_range(0, 3) == 0) b.push_back(8'h0D);
        if ($urandom_range(0, 5) == 0) begin
            pos = $urandom_range(0, b.size());
            b.insert(pos, junk[$urandom_range(0, 4)]);
        end
        f = zeros(b.size());
        if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(0, b.size());
            b.insert(pos, 8'($urandom_range(0, 255)));
            f.insert(pos, 1'b1);
        end
        run_line(b, f);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en0, err0;
        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        check("rst_en", longint'(o_en), 0);
        check("rst_err", longint'(o_err), 0);
        check("rst_mask", longint'(o_mask), 0);
        check("rst_val0", longint'(o_val0), 0);
        check("rst_val3", longint'(o_val3), 0);

        line_str("12 -345 0 32767");
        check("l1_mask", longint'(last_mask), 15);
        check("l1_val0", longint'(o_val0), 12);
        check("l1_val1", longint'(o_val1), -345);
        check("l1_val2", longint'(o_val2), 0);
        check("l1_val3", longint'(o_val3), 32767);
        check("l1_err", longint'(err_seen), 0);

        line_str("7");
        check("l2_mask", longint'(last_mask), 1);
        check("l2_val0", longint'(o_val0), 7);
        check("l2_val1", longint'(o_val1), -345);
        check("l2_val3", longint'(o_val3), 32767);

        line_str("99999 -40000\r");
        check("l3_mask", longint'(last_mask), 3);
        check("l3_val0", longint'(o_val0), 32767);
        check("l3_val1", longint'(o_val1), -32768);
        check("l3_val2", longint'(o_val2), 0);

        en0 = en_seen; err0 = err_seen;
        line_str("1 2 3 4 5");
        line_str("1a2");
        line_str("-");
        check("bad_lines_err", longint'(err_seen - err0), 3);
        check("bad_lines_en", longint'(en_seen - en0), 0);
        check("bad_lines_val0", longint'(o_val0), 32767);
        en0 = en_seen; err0 = err_seen;
        line_str("");
        check("empty_en", longint'(en_seen - en0), 0);
        check("empty_err", longint'(err_seen - err0), 0);

        en0 = en_seen; err0 = err_seen;
        run_line(str2q("x5"), '{1'b1, 1'b0});
        check("frame_err", longint'(err_seen - err0), 1);
        check("frame_en", longint'(en_seen - en0), 1);
        check("frame_val0", longint'(o_val0), 5);

        en0 = en_seen; err0 = err_seen;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(4 * CLK_DIV);
        check("glitch_strobes", longint'(en_seen - en0 + err_seen - err0), 0);

        // Reset in the middle of the '3' of "123\n".
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        rx = 1'b0;
        tick(CLK_DIV);
        rx = 1'b1;
        tick(CLK_DIV + 8);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2 * CLK_DIV);
        check("rst_mid_val0", longint'(o_val0), 0);
        check("rst_mid_val1", longint'(o_val1), 0);
        check("rst_mid_val3", longint'(o_val3), 0);
        line_str("8");
        check("after_rst_val0", longint'(o_val0), 8);
        check("after_rst_val1", longint'(o_val1), 0);

        for (int n = 0; n < 20; n++) rand_line();

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
        check("events_drained", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
